// File: rtl/flame_sequencer.sv
// flame_sequencer: runs one bomb from drop to end of explosion.
// It latches the tile position of the dropped bomb and counts the fuse in frames.
// It then steps the flame sprite index through the sheet.
// Every output is registered and changes only on frame_tick or drop edges,
// so the renderer never sees a sprite change in the middle of a frame.
module flame_sequencer #(
  parameter int FUSE_FRAMES       = 120,
  parameter int FRAMES_PER_SPRITE = 8,
  parameter int NUM_SPRITES       = 4,
  parameter int GRID_COLS         = 25,
  parameter int GRID_ROWS         = 18,
  parameter int ORIGIN_X          = 0,
  parameter int ORIGIN_Y          = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               bomb_drop,
  input  logic [4:0]         bomb_tileX,
  input  logic [4:0]         bomb_tileY,
  output logic               busy,
  output logic signed [10:0] centerXF,
  output logic signed [10:0] centerYF,
  output logic [1:0]         sprite_num,
  output logic               flame_on,
  output logic               explode_pulse,
  output logic               done_pulse
);

  localparam int CNT_MAX = (FUSE_FRAMES > FRAMES_PER_SPRITE) ? FUSE_FRAMES : FRAMES_PER_SPRITE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] FUSE_LAST = CW'(FUSE_FRAMES - 1);
  localparam logic [CW-1:0] SPR_LAST  = CW'(FRAMES_PER_SPRITE - 1);
  localparam logic [1:0]    LAST_IDX  = 2'(NUM_SPRITES - 1);
  localparam logic [5:0]    COLS_LIM  = 6'(GRID_COLS);
  localparam logic [5:0]    ROWS_LIM  = 6'(GRID_ROWS);
  localparam logic [10:0]   ORG_X     = 11'(ORIGIN_X);
  localparam logic [10:0]   ORG_Y     = 11'(ORIGIN_Y);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FUSE  = 2'd1,
    BLAST = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [10:0] cx_q, cx_d;
  logic signed [10:0] cy_q, cy_d;
  logic [1:0]         spr_q, spr_d;
  logic               flame_q, flame_d;
  logic               expl_q, expl_d;
  logic               done_q, done_d;
  logic               busy_q;
  logic               drop_ok_s;
  logic [10:0]        tile_px_x_s, tile_px_y_s;

  // The drop is accepted only when both tile coordinates are on the grid.
  // The pixel position is the origin plus the tile index shifted left by 5.
  // The result is truncated to 11 bits.
  always_comb begin
    drop_ok_s   = bomb_drop && ({1'b0, bomb_tileX} < COLS_LIM) && ({1'b0, bomb_tileY} < ROWS_LIM);
    tile_px_x_s = ORG_X + {1'b0, bomb_tileX, 5'b00000};
    tile_px_y_s = ORG_Y + {1'b0, bomb_tileY, 5'b00000};
  end

  // Next-state and next-output logic.
  // The pulse outputs default to 0, so they stay high for exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    spr_d   = spr_q;
    flame_d = flame_q;
    expl_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A frame_tick that arrives with an accepted drop is not counted.
        if (drop_ok_s) begin
          cx_d    = signed'(tile_px_x_s);
          cy_d    = signed'(tile_px_y_s);
          cnt_d   = '0;
          state_d = FUSE;
        end else begin
          state_d = IDLE;
        end
      end
      FUSE: begin
        if (frame_tick) begin
          if (cnt_q == FUSE_LAST) begin
            cnt_d   = '0;
            spr_d   = 2'd0;
            flame_d = 1'b1;
            expl_d  = 1'b1;
            state_d = BLAST;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      BLAST: begin
        if (frame_tick) begin
          if (cnt_q == SPR_LAST) begin
            cnt_d = '0;
            if (spr_q != LAST_IDX) begin
              spr_d = spr_q + 2'd1;
            end else begin
              spr_d   = 2'd0;
              flame_d = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        spr_d   = 2'd0;
        flame_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  // An asynchronous reset clears everything at once, so an aborted bomb emits no pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cx_q    <= 11'sd0;
      cy_q    <= 11'sd0;
      spr_q   <= 2'd0;
      flame_q <= 1'b0;
      expl_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      spr_q   <= spr_d;
      flame_q <= flame_d;
      expl_q  <= expl_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign busy          = busy_q;
  assign centerXF      = cx_q;
  assign centerYF      = cy_q;
  assign sprite_num    = spr_q;
  assign flame_on      = flame_q;
  assign explode_pulse = expl_q;
  assign done_pulse    = done_q;

endmodule
